rec_cmd_generator: RTL and testbench

- Sits directly downstream of the flight-mode controller and upstream of the angle controller.
- Consumes the rec_data_sel code and the raw receiver channels, and produces the throttle/yaw/roll/pitch commands the angle controller sees.
- Pass-through is a registered copy of the receiver channels. Off, take-off, hover and landing commands are generated internally with a rate-limited throttle ramp, so mode switches are bumpless.

---
 rtl/rec_cmd_generator_pkg.sv | 43 ++++
 rtl/rec_cmd_generator_throttle_ramp.sv | 62 ++++++
 rtl/rec_cmd_generator.sv | 95 +++++++++
 tb/tb_rec_cmd_generator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rec_cmd_generator_pkg.sv
// rtl/rec_cmd_generator_pkg.sv - shared codes, widths and defaults for the receiver command generator
package rec_cmd_generator_pkg;

    localparam int REC_DATA_SEL_BIT_WIDTH = 3;
    localparam int REC_VAL_BIT_WIDTH      = 8;

    localparam logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_OFF           = 3'd0;
    localparam logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_PASS_THROUGH  = 3'd1;
    localparam logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_AUTO_TAKE_OFF = 3'd2;
    localparam logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_AUTO_LAND     = 3'd3;
    localparam logic [REC_DATA_SEL_BIT_WIDTH-1:0] REC_SEL_HOVER         = 3'd4;

    localparam logic [REC_VAL_BIT_WIDTH-1:0] MOTOR_VAL_MIN_DEF      = 8'd0;
    localparam logic [REC_VAL_BIT_WIDTH-1:0] HOVER_THROTTLE_VAL_DEF = 8'd90;
    localparam logic [REC_VAL_BIT_WIDTH-1:0] NEUTRAL_VAL_DEF        = 8'd125;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PASS,
        ST_TAKEOFF,
        ST_LAND,
        ST_HOVER
    } rec_state_t;

    function automatic rec_state_t decode_sel(input logic [REC_DATA_SEL_BIT_WIDTH-1:0] sel);
        case (sel)
            REC_SEL_PASS_THROUGH:  return ST_PASS;
            REC_SEL_AUTO_TAKE_OFF: return ST_TAKEOFF;
            REC_SEL_AUTO_LAND:     return ST_LAND;
            REC_SEL_HOVER:         return ST_HOVER;
            default:               return ST_OFF;
        endcase
    endfunction

    function automatic logic sel_valid(input logic [REC_DATA_SEL_BIT_WIDTH-1:0] sel);
        return (sel <= REC_SEL_HOVER);
    endfunction

    function automatic logic is_ramp_state(input rec_state_t s);
        return (s == ST_TAKEOFF) || (s == ST_LAND) || (s == ST_HOVER);
    endfunction

endpackage

// File: rtl/rec_cmd_generator_throttle_ramp.sv
// rtl/rec_cmd_generator_throttle_ramp.sv - rate-limited throttle step toward a target
module rec_cmd_generator_throttle_ramp
    import rec_cmd_generator_pkg::*;
#(
    parameter int                           STEP_PERIOD = 20000,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] STEP_SIZE   = 8'd1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         restart,
    input  logic [REC_VAL_BIT_WIDTH-1:0] start_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0] target,
    output logic [REC_VAL_BIT_WIDTH-1:0] ramp_val,
    output logic                         at_target
);

    localparam logic [19:0] CNT_LAST = 20'(STEP_PERIOD - 1);

    logic [19:0] cnt_q;
    logic        step;
    logic [8:0]  cur9;
    logic [8:0]  tgt9;
    logic [8:0]  size9;
    logic [8:0]  up9;
    logic [8:0]  dn9;

    // A restart (state change) swallows any step due on the same cycle.
    always_comb begin
        cur9     = {1'b0, start_val};
        tgt9     = {1'b0, target};
        size9    = {1'b0, STEP_SIZE};
        up9      = cur9 + size9;
        dn9      = cur9 - size9;
        step     = enable && !restart && (cnt_q == CNT_LAST);
        ramp_val = start_val;
        if (step) begin
            if (cur9 < tgt9) begin
                ramp_val = (up9 >= tgt9) ? target : up9[7:0];
            end else if (cur9 > tgt9) begin
                ramp_val = (cur9 <= tgt9 + size9) ? target : dn9[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 20'd1;
        end

        if (reset) begin
            at_target <= 1'b0;
        end else begin
            at_target <= enable && (ramp_val == target);
        end
    end

endmodule

// File: rtl/rec_cmd_generator.sv
// rtl/rec_cmd_generator.sv - selects pass-through or generated commands for the angle controller
module rec_cmd_generator
    import rec_cmd_generator_pkg::*;
#(
    parameter int                           STEP_PERIOD        = 20000,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] STEP_SIZE          = 8'd1,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] HOVER_THROTTLE_VAL = HOVER_THROTTLE_VAL_DEF,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] MOTOR_VAL_MIN      = MOTOR_VAL_MIN_DEF,
    parameter logic [REC_VAL_BIT_WIDTH-1:0] NEUTRAL_VAL        = NEUTRAL_VAL_DEF
) (
    input  logic                              us_clk,
    input  logic                              reset,
    input  logic [REC_DATA_SEL_BIT_WIDTH-1:0] rec_data_sel,
    input  logic [REC_VAL_BIT_WIDTH-1:0]      throttle_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0]      yaw_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0]      roll_val,
    input  logic [REC_VAL_BIT_WIDTH-1:0]      pitch_val,
    output logic [REC_VAL_BIT_WIDTH-1:0]      throttle_out,
    output logic [REC_VAL_BIT_WIDTH-1:0]      yaw_out,
    output logic [REC_VAL_BIT_WIDTH-1:0]      roll_out,
    output logic [REC_VAL_BIT_WIDTH-1:0]      pitch_out,
    output logic                              at_target,
    output logic                              sel_err
);

    rec_state_t                   state_q;
    rec_state_t                   state_d;
    logic                         ramp_en;
    logic                         ramp_restart;
    logic [REC_VAL_BIT_WIDTH-1:0] ramp_target;
    logic [REC_VAL_BIT_WIDTH-1:0] ramp_val;
    logic [REC_VAL_BIT_WIDTH-1:0] throttle_d;
    logic [REC_VAL_BIT_WIDTH-1:0] yaw_d;
    logic [REC_VAL_BIT_WIDTH-1:0] roll_d;
    logic [REC_VAL_BIT_WIDTH-1:0] pitch_d;

    rec_cmd_generator_throttle_ramp #(
        .STEP_PERIOD(STEP_PERIOD),
        .STEP_SIZE  (STEP_SIZE)
    ) u_ramp (
        .clk      (us_clk),
        .reset    (reset),
        .enable   (ramp_en),
        .restart  (ramp_restart),
        .start_val(throttle_out),
        .target   (ramp_target),
        .ramp_val (ramp_val),
        .at_target(at_target)
    );

    // Outputs are computed from the decoded selector so they follow it by one cycle.
    always_comb begin
        state_d      = decode_sel(rec_data_sel);
        ramp_en      = is_ramp_state(state_d);
        ramp_restart = (state_d != state_q);
        ramp_target  = (state_d == ST_LAND) ? MOTOR_VAL_MIN : HOVER_THROTTLE_VAL;
        throttle_d   = MOTOR_VAL_MIN;
        yaw_d        = NEUTRAL_VAL;
        roll_d       = NEUTRAL_VAL;
        pitch_d      = NEUTRAL_VAL;
        case (state_d)
            ST_PASS: begin
                throttle_d = throttle_val;
                yaw_d      = yaw_val;
                roll_d     = roll_val;
                pitch_d    = pitch_val;
            end
            ST_TAKEOFF, ST_LAND, ST_HOVER: begin
                throttle_d = ramp_val;
            end
            default: begin
                throttle_d = MOTOR_VAL_MIN;
            end
        endcase
    end

    always_ff @(posedge us_clk) begin
        if (reset) begin
            state_q      <= ST_OFF;
            throttle_out <= MOTOR_VAL_MIN;
            yaw_out      <= NEUTRAL_VAL;
            roll_out     <= NEUTRAL_VAL;
            pitch_out    <= NEUTRAL_VAL;
            sel_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            throttle_out <= throttle_d;
            yaw_out      <= yaw_d;
            roll_out     <= roll_d;
            pitch_out    <= pitch_d;
            sel_err      <= sel_err | ~sel_valid(rec_data_sel);
        end
    end

endmodule

// File: tb/tb_rec_cmd_generator.sv
// tb/tb_rec_cmd_generator.sv - checks two generator instances (step 1 and 3) against a mode-level model
module tb_rec_cmd_generator;

    localparam int P     = 4;
    localparam int HOVER = 10;
    localparam int NEUT  = 125;
    localparam int SIZES [2] = '{1, 3};

    logic       us_clk = 1'b0;
    logic       reset;
    logic [2:0] rec_data_sel;
    logic [7:0] throttle_val, yaw_val, roll_val, pitch_val;

    logic [7:0] thr_o [2];
    logic [7:0] yaw_o [2];
    logic [7:0] roll_o [2];
    logic [7:0] pitch_o [2];
    logic       at_o [2];
    logic       err_o [2];

    int n_pass  = 0;
    int n_total = 0;
    int cyc_no  = 0;

    int m_mode [2];
    int m_age [2];
    int m_thr [2];
    int m_yaw [2];
    int m_roll [2];
    int m_pitch [2];
    int m_at [2];
    int m_err [2];

    always #5 us_clk = ~us_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rec_cmd_generator #(
            .STEP_PERIOD       (P),
            .STEP_SIZE         (8'(SIZES[g])),
            .HOVER_THROTTLE_VAL(8'(HOVER)),
            .MOTOR_VAL_MIN     (8'd0),
            .NEUTRAL_VAL       (8'(NEUT))
        ) u_dut (
            .us_clk      (us_clk),
            .reset       (reset),
            .rec_data_sel(rec_data_sel),
            .throttle_val(throttle_val),
            .yaw_val     (yaw_val),
            .roll_val    (roll_val),
            .pitch_val   (pitch_val),
            .throttle_out(thr_o[g]),
            .yaw_out     (yaw_o[g]),
            .roll_out    (roll_o[g]),
            .pitch_out   (pitch_o[g]),
            .at_target   (at_o[g]),
            .sel_err     (err_o[g])
        );
    end

    // Mode-level rules: steps land every P edges after entering a ramp mode, moving min(size,|gap|).
    task automatic model_update(input int i, input bit rst, input int sel,
                                input int t, input int y, input int r, input int p);
        int nm;
        int tgt;
        int d;
        bit entered;
        if (rst) begin
            m_mode[i] = 0; m_age[i] = 0; m_thr[i] = 0;
            m_yaw[i] = NEUT; m_roll[i] = NEUT; m_pitch[i] = NEUT;
            m_at[i] = 0; m_err[i] = 0;
            return;
        end
        nm = (sel <= 4) ? sel : 0;
        if (sel > 4) m_err[i] = 1;
        entered = (nm != m_mode[i]);
        m_age[i] = entered ? 0 : m_age[i] + 1;
        m_mode[i] = nm;
        if (nm == 0) begin
            m_thr[i] = 0; m_yaw[i] = NEUT; m_roll[i] = NEUT; m_pitch[i] = NEUT; m_at[i] = 0;
        end else if (nm == 1) begin
            m_thr[i] = t; m_yaw[i] = y; m_roll[i] = r; m_pitch[i] = p; m_at[i] = 0;
        end else begin
            tgt = (nm == 3) ? 0 : HOVER;
            m_yaw[i] = NEUT; m_roll[i] = NEUT; m_pitch[i] = NEUT;
            if (!entered && (m_age[i] % P == 0)) begin
                d = tgt - m_thr[i];
                if (d > SIZES[i]) d = SIZES[i];
                if (d < -SIZES[i]) d = -SIZES[i];
                m_thr[i] = m_thr[i] + d;
            end
            m_at[i] = (m_thr[i] == tgt) ? 1 : 0;
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [7:0] obs, input int exp);
        logic [7:0] e;
        e = 8'(exp);
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s[%0d] cycle %0d: got %0d expected %0d", tag, i, cyc_no, obs, e);
    endtask

    task automatic cyc(input bit rst, input int sel, input int t, input int y, input int r, input int p);
        reset        = rst;
        rec_data_sel = 3'(sel);
        throttle_val = 8'(t);
        yaw_val      = 8'(y);
        roll_val     = 8'(r);
        pitch_val    = 8'(p);
        @(posedge us_clk);
        #1;
        cyc_no++;
        for (int i = 0; i < 2; i++) begin
            model_update(i, rst, sel, t, y, r, p);
            chk("throttle", i, thr_o[i], m_thr[i]);
            chk("yaw", i, yaw_o[i], m_yaw[i]);
            chk("roll", i, roll_o[i], m_roll[i]);
            chk("pitch", i, pitch_o[i], m_pitch[i]);
            chk("at_target", i, {7'd0, at_o[i]}, m_at[i]);
            chk("sel_err", i, {7'd0, err_o[i]}, m_err[i]);
        end
    endtask

    task automatic cyc_rand(input bit rst, input int sel);
        cyc(rst, sel, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    initial begin
        int sel;
        for (int i = 0; i < 2; i++) model_update(i, 1'b1, 0, 0, 0, 0, 0);

        // Reset with pass-through selected, then release.
        repeat (3) cyc(1'b1, 1, 200, 1, 2, 3);
        cyc(1'b0, 1, 200, 11, 22, 33);

        // Take-off from zero up to the hover value and holding there.
        cyc_rand(1'b0, 0);
        repeat (46) cyc_rand(1'b0, 2);

        // Landing from the last pass-through throttle.
        repeat (2) cyc(1'b0, 1, 50, 60, 70, 80);
        repeat (60) cyc_rand(1'b0, 3);

        // Take-off to 6, then switch to hover exactly on a step cycle.
        cyc_rand(1'b0, 0);
        repeat (28) cyc_rand(1'b0, 2);
        repeat (10) cyc_rand(1'b0, 4);

        // Invalid selector is sticky until reset.
        cyc_rand(1'b0, 6);
        repeat (5) cyc_rand(1'b0, 1);

        // Clamped step near the target (step-3 instance goes 8 -> 10).
        repeat (2) cyc(1'b0, 1, 8, 9, 9, 9);
        repeat (6) cyc_rand(1'b0, 2);

        // Above-target entry into hover ramps down.
        repeat (2) cyc(1'b0, 1, 30, 1, 1, 1);
        repeat (30) cyc_rand(1'b0, 4);

        cyc_rand(1'b1, 1);

        // Randomized selector dwell with occasional resets.
        sel = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                sel = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            end
            cyc_rand($urandom_range(0, 499) == 0, sel);
        end

        repeat (2) cyc_rand(1'b1, 7);
        cyc_rand(1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
